util_tx_burst_sched: RTL
========================

Name: util_tx_burst_sched

Overview:
- DAC-clock-domain scheduler that owns the 64-bit sample timestamp counter fed to the timestamped upack path.
- Gates consumption of unpacked TX data: the datapath is armed with a start time and an optional burst length, and data is pulled only inside the scheduled window.
- Counts underflows, i.e. sample slots where data was demanded but not valid.
- Sits between the DAC core sample strobe and the timestamp-checking upack output handshake.

Parameters:
- TS_WIDTH, 64, timestamp counter width in bits.
- LEN_WIDTH, 32, burst length and underflow counter width in bits.

Ports:
- dac_clk  input  1  sole clock
- reset  input  1  synchronous, active-high reset
- dac_valid  input  1  DAC sample-slot strobe; one slot per asserted cycle
- ts_load  input  1  pulse: load timestamp from ts_load_value
- ts_load_value  input  TS_WIDTH  timestamp load value
- arm  input  1  pulse: arm burst using start_time / burst_len
- abort  input  1  pulse: return to IDLE immediately
- start_time  input  TS_WIDTH  first sample timestamp of burst, sampled on accepted arm
- burst_len  input  LEN_WIDTH  samples per burst, sampled on accepted arm; 0 = continuous
- data_valid  input  1  m_axis_valid from timestamped upack
- data_ready  output  1  m_axis_ready to timestamped upack
- timestamp  output  TS_WIDTH  current sample timestamp, to upack timestamp input
- tx_active  output  1  high in RUNNING
- busy  output  1  high when state != IDLE
- burst_done  output  1  one-cycle pulse after last burst sample consumed
- underflow  output  1  sticky underflow flag
- underflow_count  output  LEN_WIDTH  saturating underflow count
- underflow_clr  input  1  pulse: clear underflow and underflow_count
- late_start  output  1  one-cycle pulse; driven only when UTIL_TX_SCHED_LATE_REJECT_EN is defined, else tied 0

Behaviour:
- Reset: state IDLE; timestamp, counters, flags and all outputs 0.
- Timestamp counter: ts_load wins over increment. Otherwise the counter increments by 1 on each dac_valid cycle. Unsigned wrap from 2^TS_WIDTH-1 to 0. Counts in every state.
- FSM states: IDLE, ARMED, RUNNING.
- IDLE -> ARMED on arm. start_time and burst_len are latched into internal registers; arm is ignored outside IDLE.
- go = ARMED && dac_valid && (timestamp >= latched start_time), unsigned compare against the pre-increment value.
- data_ready = dac_valid && (RUNNING || go). This is combinational, so the slot with timestamp == start_time is the first one consumed.
- Consumed slot = data_ready high. Sample counter resets to 0 on arm and increments per consumed slot.
- ARMED -> RUNNING on go. If burst_len == 1, go goes directly to IDLE and burst_done pulses the next cycle.
- RUNNING -> IDLE on the consumed slot where sample counter == burst_len-1 (burst_len != 0). burst_done is registered, high the following cycle for 1 cycle.
- burst_len == 0: RUNNING persists until abort.
- abort: any state -> IDLE next cycle. abort beats arm, go and burst end in the same cycle. No burst_done pulse on abort.
- Underflow event = data_ready && !data_valid. Effects: underflow set, underflow_count +1 saturating at all-ones. The slot still counts toward burst_len, because time advances regardless.
- underflow_clr in the same cycle as an event: count = 1 and flag = 1, so the event wins over the clear.
- ts_load while ARMED/RUNNING is allowed; later comparisons use the new value. The burst is not restarted.
- Reset mid-burst: immediate IDLE with all counters cleared. data_ready drops in the same cycle as reset is sampled.
- tx_active = (state == RUNNING); busy = (state != IDLE). Both are decoded from registered state, with no combinational path from inputs.

Optional Feature:
- Macro UTIL_TX_SCHED_LATE_REJECT_EN.
- Defined: an arm accepted in IDLE with latched start_time < timestamp (that cycle's value) does not enter ARMED. The state stays IDLE, late_start pulses 1 cycle later, and no data is consumed.
- Undefined: such an arm enters ARMED and starts on the next dac_valid (go is true immediately). late_start is tied 0.

Decomposition:
- Package util_tx_burst_sched_pkg:
  - state enum {IDLE, ARMED, RUNNING}
  - default TS_WIDTH / LEN_WIDTH constants
- Natural sub-module: util_tx_timestamp_counter, holding the loadable 64-bit free-running counter with dac_valid enable and load priority.

Test Plan:
- Load 100, arm start=105 len=4, dac_valid every cycle -> data_ready first high at timestamp 105, high for 105..108, burst_done one cycle after 108, busy low.
- Arm start=50 len=0 at timestamp 40, data_valid low at timestamps 52 and 53, then abort at 60 -> underflow_count=2, underflow=1, data_ready low from cycle after abort, no burst_done.
- dac_valid every 3rd cycle, start=10 len=2 -> data_ready only on dac_valid cycles at timestamps 10 and 11, counter advances only on strobes.
- Arm with start=20 at timestamp 30 -> macro undefined: RUNNING on next strobe, data_ready high; macro defined: stays IDLE, late_start pulse, data_ready never high.
- ts_load 0xFFFF_FFFF_FFFF_FFFE, 3 strobes -> timestamp FE, FF, 0, 1 sequence (wrap); underflow_clr coincident with event -> count=1.
- Reset asserted mid-RUNNING with len=0 -> next cycle state IDLE, timestamp=0, underflow_count=0, busy=0.

Source files
------------

// File: rtl/util_tx_burst_sched_pkg.sv
// Shared types and default widths for the TX burst scheduler and its timestamp counter.
package util_tx_burst_sched_pkg;
  localparam int TS_WIDTH_DEF  = 64;
  localparam int LEN_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2
  } state_t;
endpackage

// File: rtl/util_tx_burst_sched_if.sv
// Output handshake between the scheduler and the timestamped upack stream (valid/ready plus sample timestamp).
interface util_tx_burst_sched_if
  import util_tx_burst_sched_pkg::*;
#(
  parameter int TS_WIDTH = TS_WIDTH_DEF
);
  logic                data_valid;
  logic                data_ready;
  logic [TS_WIDTH-1:0] timestamp;

  modport master (input data_valid, output data_ready, output timestamp);
  modport slave  (output data_valid, input data_ready, input timestamp);
endinterface

// File: rtl/util_tx_timestamp_counter.sv
// Loadable free-running sample timestamp; advances once per DAC slot, a load takes priority over the increment.
module util_tx_timestamp_counter
  import util_tx_burst_sched_pkg::*;
#(
  parameter int TS_WIDTH = TS_WIDTH_DEF
) (
  input  logic                dac_clk,
  input  logic                reset,
  input  logic                dac_valid,
  input  logic                ts_load,
  input  logic [TS_WIDTH-1:0] ts_load_value,
  output logic [TS_WIDTH-1:0] timestamp
);
  localparam logic [TS_WIDTH-1:0] TS_ONE = TS_WIDTH'(1);

  always_ff @(posedge dac_clk) begin
    if (reset) begin
      timestamp <= '0;
    end else if (ts_load) begin
      timestamp <= ts_load_value;
    end else if (dac_valid) begin
      timestamp <= timestamp + TS_ONE;
    end
  end
endmodule

// File: rtl/util_tx_burst_sched.sv
// DAC-domain TX burst scheduler: opens a consumption window at start_time for burst_len slots and tracks underflows.
// Optional macro UTIL_TX_SCHED_LATE_REJECT_EN: reject arms whose start_time is already in the past.
module util_tx_burst_sched
  import util_tx_burst_sched_pkg::*;
#(
  parameter int TS_WIDTH  = TS_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                  dac_clk,
  input  logic                  reset,
  input  logic                  dac_valid,
  input  logic                  ts_load,
  input  logic [TS_WIDTH-1:0]   ts_load_value,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [TS_WIDTH-1:0]   start_time,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  util_tx_burst_sched_if.master bus,
  output logic                  tx_active,
  output logic                  busy,
  output logic                  burst_done,
  output logic                  underflow,
  output logic [LEN_WIDTH-1:0]  underflow_count,
  input  logic                  underflow_clr,
  output logic                  late_start
);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t               state, state_nxt;
  logic [TS_WIDTH-1:0]  ts;
  logic [TS_WIDTH-1:0]  start_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [LEN_WIDTH-1:0] uf_cnt_q;
  logic                 uf_q;
  logic                 burst_done_p1;
  logic                 go, ready, last, uf_evt, late_rej, arm_ok;

  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    return (&v) ? v : v + LEN_ONE;
  endfunction

  util_tx_timestamp_counter #(.TS_WIDTH(TS_WIDTH)) u_ts (
    .dac_clk       (dac_clk),
    .reset         (reset),
    .dac_valid     (dac_valid),
    .ts_load       (ts_load),
    .ts_load_value (ts_load_value),
    .timestamp     (ts)
  );

`ifdef UTIL_TX_SCHED_LATE_REJECT_EN
  logic late_start_p1;
  assign late_rej = (start_time < ts);
  always_ff @(posedge dac_clk) begin
    if (reset) late_start_p1 <= 1'b0;
    else       late_start_p1 <= (state == IDLE) && arm && !abort && late_rej;
  end
  assign late_start = late_start_p1;
`else
  assign late_rej   = 1'b0;
  assign late_start = 1'b0;
`endif

  // Window decode: go compares against the pre-increment timestamp so the start_time slot itself is consumed.
  assign go     = (state == ARMED) && dac_valid && (ts >= start_q);
  assign ready  = dac_valid && !reset && ((state == RUNNING) || go);
  assign last   = ready && (len_q != '0) && (cnt_q == len_q - LEN_ONE);
  assign uf_evt = ready && !bus.data_valid;
  assign arm_ok = (state == IDLE) && arm && !abort && !late_rej;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm && !late_rej) state_nxt = ARMED;
      ARMED:   if (go) state_nxt = last ? IDLE : RUNNING;
      RUNNING: if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge dac_clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt_q         <= '0;
      uf_q          <= 1'b0;
      uf_cnt_q      <= '0;
      burst_done_p1 <= 1'b0;
    end else begin
      state         <= state_nxt;
      burst_done_p1 <= last && !abort;
      if (arm_ok)     cnt_q <= '0;
      else if (ready) cnt_q <= cnt_q + LEN_ONE;
      // A coincident event beats the clear so that slot is never lost.
      if (uf_evt) begin
        uf_q     <= 1'b1;
        uf_cnt_q <= underflow_clr ? LEN_ONE : sat_inc(uf_cnt_q);
      end else if (underflow_clr) begin
        uf_q     <= 1'b0;
        uf_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge dac_clk) begin
    if (arm_ok) begin
      start_q <= start_time;
      len_q   <= burst_len;
    end
  end

  assign bus.data_ready  = ready;
  assign bus.timestamp   = ts;
  assign tx_active       = (state == RUNNING);
  assign busy            = (state != IDLE);
  assign burst_done      = burst_done_p1;
  assign underflow       = uf_q;
  assign underflow_count = uf_cnt_q;
endmodule
